// File: rtl/dp_exec.sv
// Datapath executor: responder side of the start/instruction/finished/result
// handshake used by the draw FSMs. Executes LOAD, STORE and single-pixel DRAW.
module dp_exec #(
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int RESULT_WIDTH   = 16,
  parameter int MEM_LATENCY    = 1
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [31:0]               instruction,
  output logic                      finished,
  output logic [RESULT_WIDTH-1:0]   result,
  output logic                      bad_op,
  output logic                      busy,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic                      mem_rd,
  output logic                      mem_wr,
  output logic [RESULT_WIDTH-1:0]   mem_wdata,
  input  logic [RESULT_WIDTH-1:0]   mem_rdata,
  output logic [7:0]                vga_x,
  output logic [6:0]                vga_y,
  output logic [2:0]                vga_colour,
  output logic                      vga_plot
);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_DRAW  = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;

  // Counter preload so that mem_rdata is sampled MEM_LATENCY edges after acceptance.
  localparam logic [2:0] LAT_INIT = 3'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    DONE
  } state_t;

  state_t      state;
  logic [3:0]  op_q;
  logic [11:0] imm_q;
  logic [2:0]  lat_cnt;
  logic [3:0]  op;

  assign op = instruction[31:28];

  // NOTE: the reset is synchronous, so it lives inside the clocked branch and
  // the process is sensitive to the clock edge only.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      op_q       <= OP_NOP;
      imm_q      <= '0;
      lat_cnt    <= '0;
      finished   <= 1'b0;
      result     <= '0;
      bad_op     <= 1'b0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every register
      // updates from the values present before this edge.
      case (state)
        IDLE: begin
          finished <= 1'b0;
          bad_op   <= 1'b0;
          mem_rd   <= 1'b0;
          mem_wr   <= 1'b0;
          vga_plot <= 1'b0;
          if (start) begin
            op_q  <= op;
            imm_q <= instruction[27:16];
            busy  <= 1'b1;
            case (op)
              OP_LOAD: begin
                mem_addr <= instruction[MEM_ADDR_WIDTH-1:0];
                mem_rd   <= 1'b1;
                lat_cnt  <= LAT_INIT;
                state    <= LOAD_WAIT;
              end
              OP_STORE: begin
                mem_addr  <= instruction[MEM_ADDR_WIDTH-1:0];
                mem_wdata <= RESULT_WIDTH'(instruction[27:16]);
                mem_wr    <= 1'b1;
                state     <= DONE;
              end
              OP_DRAW: begin
                vga_x      <= instruction[7:0];
                vga_y      <= instruction[14:8];
                vga_colour <= instruction[17:15];
                vga_plot   <= instruction[18];
                state      <= DONE;
              end
              default: state <= DONE;
            endcase
          end
        end

        LOAD_WAIT: begin
          mem_rd <= 1'b0;
          if (lat_cnt == 3'd0) begin
            result   <= mem_rdata;
            finished <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end

        DONE: begin
          mem_rd   <= 1'b0;
          mem_wr   <= 1'b0;
          vga_plot <= 1'b0;
          finished <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
          case (op_q)
            OP_STORE:       result <= RESULT_WIDTH'(imm_q);
            OP_DRAW, OP_NOP: result <= '0;
            default: begin
              result <= '0;
              bad_op <= (op_q > OP_STORE);
            end
          endcase
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_exec.sv
// Bench for dp_exec: three instances (latency 1, 3, 4) driven one at a time by
// directed scenarios and random instruction streams checked against a transaction model.
module tb_dp_exec;

  logic        clock = 1'b0;
  logic        resetn      [3];
  logic        start       [3];
  logic [31:0] instruction [3];
  logic        finished    [3];
  logic [15:0] result      [3];
  logic        bad_op      [3];
  logic        busy        [3];
  logic [15:0] mem_addr    [3];
  logic        mem_rd      [3];
  logic        mem_wr      [3];
  logic [15:0] mem_wdata   [3];
  logic [7:0]  vga_x       [3];
  logic [6:0]  vga_y       [3];
  logic [2:0]  vga_colour  [3];
  logic        vga_plot    [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Bench RAM shared by all instances; unwritten locations read a fixed pattern.
  logic [15:0] ram     [65536];
  bit          written [65536];
  logic        pl_we   = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  // Reference memory and last completed result per instance.
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] last_res [3];

  always #5 clock = ~clock;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] ram_read(input logic [15:0] a);
    return written[a] ? ram[a] : init_val(a);
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 4;
  endfunction

  always @(posedge clock) begin
    if (pl_we) begin
      ram[pl_addr]     <= pl_data;
      written[pl_addr] <= 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      if (mem_wr[i] === 1'b1) begin
        ram[mem_addr[i]]     <= mem_wdata[i];
        written[mem_addr[i]] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    logic [15:0] rdata = 16'hDEAD;
    logic [3:0]  age   = 4'd0;

    dp_exec #(
      .MEM_ADDR_WIDTH(16),
      .RESULT_WIDTH  (16),
      .MEM_LATENCY   (LAT)
    ) u_dut (
      .clock      (clock),
      .resetn     (resetn[g]),
      .start      (start[g]),
      .instruction(instruction[g]),
      .finished   (finished[g]),
      .result     (result[g]),
      .bad_op     (bad_op[g]),
      .busy       (busy[g]),
      .mem_addr   (mem_addr[g]),
      .mem_rd     (mem_rd[g]),
      .mem_wr     (mem_wr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_rdata  (rdata),
      .vga_x      (vga_x[g]),
      .vga_y      (vga_y[g]),
      .vga_colour (vga_colour[g]),
      .vga_plot   (vga_plot[g])
    );

    // Cycles elapsed since the read strobe was seen.
    always @(posedge clock) begin
      if (mem_rd[g] === 1'b1) age <= 4'd1;
      else if (age != 4'd0 && age < 4'd15) age <= age + 4'd1;
    end

    // Read data is valid only for the edge exactly LAT cycles after acceptance.
    always @(negedge clock) begin
      if ((mem_rd[g] === 1'b1 && LAT == 1) ||
          (mem_rd[g] !== 1'b1 && age != 4'd0 && int'(age) + 1 == LAT))
        rdata <= ram_read(mem_addr[g]);
      else
        rdata <= 16'hDEAD;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input int k);
    string t;
    t = $sformatf("reset k%0d", k);
    check({t, " finished"}, 32'(finished[k]), 0);
    check({t, " result"},   32'(result[k]),   0);
    check({t, " bad_op"},   32'(bad_op[k]),   0);
    check({t, " busy"},     32'(busy[k]),     0);
    check({t, " mem_addr"}, 32'(mem_addr[k]), 0);
    check({t, " mem_rd"},   32'(mem_rd[k]),   0);
    check({t, " mem_wr"},   32'(mem_wr[k]),   0);
    check({t, " mem_wdata"},32'(mem_wdata[k]),0);
    check({t, " vga_x"},    32'(vga_x[k]),    0);
    check({t, " vga_y"},    32'(vga_y[k]),    0);
    check({t, " vga_colour"},32'(vga_colour[k]),0);
    check({t, " vga_plot"}, 32'(vga_plot[k]), 0);
  endtask

  // One complete transaction: accept, observe every cycle until completion.
  task automatic issue(input int k, input logic [31:0] ins);
    logic [3:0]  op;
    logic [15:0] exp_res;
    int          lat;
    string       t;
    op  = ins[31:28];
    lat = (op == 4'd2) ? lat_of(k) : 1;
    case (op)
      4'd2:    exp_res = ref_read(ins[15:0]);
      4'd3: begin
        exp_res = {4'h0, ins[27:16]};
        ref_mem[ins[15:0]] = exp_res;
      end
      default: exp_res = 16'h0000;
    endcase
    t = $sformatf("k%0d ins=%h", k, ins);

    @(negedge clock);
    start[k]       = 1'b1;
    instruction[k] = ins;
    @(negedge clock);
    start[k]       = 1'b0;
    instruction[k] = $urandom;
    check({t, " c1 busy"},     32'(busy[k]),     1);
    check({t, " c1 finished"}, 32'(finished[k]), 0);
    check({t, " c1 result"},   32'(result[k]),   32'(last_res[k]));
    check({t, " c1 mem_rd"},   32'(mem_rd[k]),   32'(op == 4'd2));
    check({t, " c1 mem_wr"},   32'(mem_wr[k]),   32'(op == 4'd3));
    check({t, " c1 vga_plot"}, 32'(vga_plot[k]), 32'(op == 4'd1 && ins[18]));
    if (op == 4'd2 || op == 4'd3) check({t, " c1 mem_addr"}, 32'(mem_addr[k]), 32'(ins[15:0]));
    if (op == 4'd3) check({t, " c1 mem_wdata"}, 32'(mem_wdata[k]), 32'(ins[27:16]));
    if (op == 4'd1) begin
      check({t, " c1 vga_x"},      32'(vga_x[k]),      32'(ins[7:0]));
      check({t, " c1 vga_y"},      32'(vga_y[k]),      32'(ins[14:8]));
      check({t, " c1 vga_colour"}, 32'(vga_colour[k]), 32'(ins[17:15]));
    end
    for (int c = 2; c <= lat; c++) begin
      @(negedge clock);
      check({t, " wait finished"}, 32'(finished[k]), 0);
      check({t, " wait busy"},     32'(busy[k]),     1);
      check({t, " wait mem_rd"},   32'(mem_rd[k]),   0);
    end
    @(negedge clock);
    check({t, " done finished"}, 32'(finished[k]), 1);
    check({t, " done result"},   32'(result[k]),   32'(exp_res));
    check({t, " done bad_op"},   32'(bad_op[k]),   32'(op > 4'd3));
    check({t, " done busy"},     32'(busy[k]),     0);
    check({t, " done strobes"},  {29'd0, mem_rd[k], mem_wr[k], vga_plot[k]}, 0);
    last_res[k] = exp_res;
  endtask

  function automatic logic [31:0] rand_instr();
    int          sel;
    logic [31:0] r;
    logic [15:0] a;
    sel = $urandom_range(0, 9);
    r   = $urandom;
    a   = (sel % 2 == 0) ? 16'(16'h0010 + $urandom_range(0, 7)) : r[15:0];
    if (sel <= 2)      return {4'h2, r[27:16], a};
    else if (sel <= 4) return {4'h3, r[27:16], a};
    else if (sel <= 6) return {4'h1, r[27:0]};
    else if (sel == 7) return {4'h0, r[27:0]};
    else               return {4'($urandom_range(4, 15)), r[27:0]};
  endfunction

  initial begin
    logic [31:0] dr;
    for (int k = 0; k < 3; k++) begin
      resetn[k]      = 1'b0;
      start[k]       = 1'b0;
      instruction[k] = '0;
      last_res[k]    = '0;
    end
    repeat (2) @(negedge clock);
    for (int k = 0; k < 3; k++) check_reset_state(k);
    for (int k = 0; k < 3; k++) resetn[k] = 1'b1;

    // Preload RAM[5] = 0xBEEF.
    @(negedge clock);
    pl_we = 1'b1; pl_addr = 16'h0005; pl_data = 16'hBEEF;
    ref_mem[16'h0005] = 16'hBEEF;
    @(negedge clock);
    pl_we = 1'b0;

    // Directed scenarios on the latency-1 instance.
    issue(0, 32'h2000_0005);
    issue(0, {4'h1, 9'd0, 1'b1, 3'b010, 7'd45, 8'd100});
    issue(0, {4'h1, 9'h1FF, 1'b0, 3'b111, 7'd3, 8'd7});
    issue(0, {4'h3, 12'hABC, 16'h0010});
    issue(0, 32'h2000_0010);
    issue(0, 32'hF000_0000);
    issue(0, 32'h0FFF_FFFF);

    // Start held during a latency-4 LOAD is ignored until the finished cycle.
    dr = {4'h1, 9'd0, 1'b1, 3'd5, 7'd10, 8'd20};
    @(negedge clock);
    start[2] = 1'b1; instruction[2] = 32'h2000_0005;
    @(negedge clock);
    instruction[2] = dr;
    check("busy-hold c1 mem_rd", 32'(mem_rd[2]), 1);
    check("busy-hold c1 plot",   32'(vga_plot[2]), 0);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clock);
      check("busy-hold plot",     32'(vga_plot[2]), 0);
      check("busy-hold finished", 32'(finished[2]), 0);
      check("busy-hold busy",     32'(busy[2]), 1);
    end
    @(negedge clock);
    check("busy-hold finished c5", 32'(finished[2]), 1);
    check("busy-hold result c5",   32'(result[2]),   32'h0000_BEEF);
    check("busy-hold plot c5",     32'(vga_plot[2]), 0);
    @(negedge clock);
    start[2] = 1'b0;
    check("busy-hold plot c6",   32'(vga_plot[2]), 1);
    check("busy-hold x c6",      32'(vga_x[2]), 20);
    check("busy-hold y c6",      32'(vga_y[2]), 10);
    check("busy-hold colour c6", 32'(vga_colour[2]), 5);
    check("busy-hold fin c6",    32'(finished[2]), 0);
    @(negedge clock);
    check("busy-hold fin c7",    32'(finished[2]), 1);
    check("busy-hold result c7", 32'(result[2]), 0);
    last_res[2] = 16'h0000;

    // Reset one cycle after a latency-3 LOAD is accepted.
    @(negedge clock);
    start[1] = 1'b1; instruction[1] = 32'h2000_0005;
    @(negedge clock);
    start[1] = 1'b0; resetn[1] = 1'b0;
    check("rst-mid mem_rd", 32'(mem_rd[1]), 1);
    @(negedge clock);
    resetn[1] = 1'b1;
    check("rst-mid busy",     32'(busy[1]), 0);
    check("rst-mid mem_addr", 32'(mem_addr[1]), 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("rst-mid finished", 32'(finished[1]), 0);
      check("rst-mid result",   32'(result[1]),   0);
    end
    last_res[1] = 16'h0000;
    issue(1, 32'h2000_0005);

    // Random instruction streams on each instance.
    for (int k = 0; k < 3; k++)
      for (int n = 0; n < 40; n++)
        issue(k, rand_instr());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dp_exec.md
# dp_exec

Datapath executor: the responder side of the `start_dp`/`instruction_dp`/`finished_dp`/`result_dp` handshake that the drawing FSMs (ant, food, grid renderers) use as initiators. It accepts one 32-bit instruction per handshake and decodes it. It then performs a memory load, a memory store, or a single VGA pixel plot, and returns a one-cycle `finished` pulse with a result word. It sits between the per-object draw FSMs (through an arbiter) and the shared game-state RAM and VGA adapter.

## Interface
- `MEM_ADDR_WIDTH`, 16, RAM address width and the instruction address field.
- `RESULT_WIDTH`, 16, RAM data width and result width.
- `MEM_LATENCY`, 1, cycles from the RAM read strobe to valid read data; legal range 1–7.
- `clock`  in  1  system clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `start`  in  1  instruction valid; sampled only in IDLE.
- `instruction`  in  32  {op[31:28], payload[27:0]}.
- `finished`  out  1  one-cycle completion pulse.
- `result`  out  RESULT_WIDTH  completion data; holds until the next completion.
- `bad_op`  out  1  high together with `finished` for undefined opcodes.
- `busy`  out  1  high from acceptance until the `finished` pulse, inclusive of nothing after it.
- `mem_addr`  out  MEM_ADDR_WIDTH  RAM address.
- `mem_rd`  out  1  one-cycle read strobe.
- `mem_wr`  out  1  one-cycle write strobe.
- `mem_wdata`  out  RESULT_WIDTH  RAM write data.
- `mem_rdata`  in  RESULT_WIDTH  RAM read data.
- `vga_x`  out  8  pixel x.
- `vga_y`  out  7  pixel y.
- `vga_colour`  out  3  pixel colour.
- `vga_plot`  out  1  one-cycle VGA write enable.

## Operation
- **Opcodes.**
  - 0 NOP.
  - 1 DRAW: {1, 9'reserved, plot[18], colour[17:15], y[14:8], x[7:0]}.
  - 2 LOAD: {2, 12'reserved, addr[15:0]}.
  - 3 STORE: {3, imm[27:16], addr[15:0]}.
  - 4–15 undefined. Reserved bits are ignored.
- **States:** IDLE, LOAD_WAIT, DONE. Every output is registered.
- **IDLE, `start`=0:** stay in IDLE; all strobes stay 0.
- **IDLE, `start`=1 (acceptance edge E0):**
  - Latch the instruction and set `busy`.
  - LOAD: `mem_addr`<=addr, `mem_rd`<=1, latency counter<=`MEM_LATENCY`-1, go to LOAD_WAIT.
  - STORE: `mem_addr`<=addr, `mem_wdata`<=zero-extended imm, `mem_wr`<=1, go to DONE.
  - DRAW: `vga_x`/`vga_y`/`vga_colour` <= fields, `vga_plot`<=plot bit, go to DONE.
  - NOP and undefined: go to DONE.
- **LOAD_WAIT:**
  - `mem_rd`<=0.
  - When the counter reaches 0: `result`<=`mem_rdata`, `finished`<=1, `busy`<=0, go to IDLE.
  - Otherwise decrement the counter.
- **DONE:** clear all strobes and set `finished`<=1, `busy`<=0. Set `result` by opcode:
  - STORE: zero-extended imm.
  - DRAW: 0.
  - NOP: 0.
  - Undefined: 0, with `bad_op`<=1.
  - Then go to IDLE.
- **Pulse clearing:** `finished` and `bad_op` clear on the next edge. `vga_x`/`vga_y`/`vga_colour`/`mem_addr`/`mem_wdata` hold their last values.
- **Back-to-back:** a `start` sampled in the cycle where `finished`=1 (state already IDLE) is accepted. An initiator that holds `start` high therefore re-issues its instruction every completion.
- **Start while busy:** ignored, never queued; the latched instruction is unaffected by `instruction` changes after E0.
- **Reset:** `resetn`=0 at any edge, including mid-LOAD, forces IDLE. It clears `finished`, `bad_op`, `busy`, `mem_rd`, `mem_wr`, `vga_plot`, `result`, `mem_addr`, `mem_wdata`, `vga_x`, `vga_y` and `vga_colour` to 0. Late `mem_rdata` from an abandoned LOAD is never captured.

## Timing
- Every output reads 0 after reset.
- **LOAD**
  - `mem_rd` high for the single cycle after E0.
  - `mem_rdata` sampled at edge E0+`MEM_LATENCY`.
  - `finished` high in the cycle after E0+`MEM_LATENCY`. Default latency is 1 cycle: `finished` is high the cycle after E0+1.
- **STORE/DRAW/NOP/undefined**
  - Strobe (`mem_wr` or `vga_plot`) high in the cycle after E0.
  - `finished` high in the cycle after E0+1.
  - The strobe never overlaps `finished`.
- **Throughput:** the minimum start-to-start spacing is 2 cycles for non-LOAD instructions and `MEM_LATENCY`+1 cycles for LOAD.
- `busy` is combinationally equivalent to (state != IDLE).

## Test plan
- **Reset then LOAD:** RAM[0x0005]=0xBEEF, `start` pulse with 0x20000005, `MEM_LATENCY`=1.
  - `mem_rd` is high for 1 cycle with `mem_addr`=0x0005.
  - `finished` is high exactly 1 cycle later, with `result`=0xBEEF and `bad_op`=0.
- **DRAW:** instruction {1, 0, 1, 3'b010, 7'd45, 8'd100}.
  - One `vga_plot` pulse with x=100, y=45, colour=2.
  - `finished` follows 1 cycle later with `result`=0.
  - With the plot bit=0: `vga_plot` stays 0 and `finished` still pulses.
- **STORE then LOAD:** STORE with imm=0xABC to addr 0x0010 gives `mem_wr` with `mem_wdata`=0x0ABC and `result`=0x0ABC. The following LOAD of 0x0010 returns 0x0ABC.
- **Undefined opcode 0xF:** `finished` and `bad_op` both pulse one cycle after acceptance; no `mem_rd`, `mem_wr` or `vga_plot`.
- **Ignore while busy:** with `MEM_LATENCY`=4, LOAD accepted, then `start` with a DRAW held for 3 cycles. No `vga_plot` appears; the held `start` is accepted in the `finished` cycle, and the plot follows 1 cycle later.
- **Reset mid-LOAD:** `resetn`=0 for 1 cycle, 1 cycle after LOAD acceptance (`MEM_LATENCY`=3). No `finished` pulse appears, `result`=0, and the next LOAD completes normally.
